// File: rtl/m_qseq_pkg.sv
// Shared types and constants for the Q-register sequencer.
package m_qseq_pkg;

  // Default width of the shift-amount counter (shift amounts 0..31).
  localparam int CNTW_DEF = 5;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    DECODE = 3'd2,
    SHLOAD = 3'd3,
    SHIFT  = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

// File: rtl/m_qseq_cnt.sv
// Loadable down-counter holding the remaining shift steps.
// Flags is_one / is_zero let the sequencer decide the last step without
// an extra compare in the FSM.
module m_qseq_cnt
  import m_qseq_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            load,
  input  logic            dec,
  input  logic [CNTW-1:0] load_val,
  output logic [CNTW-1:0] cnt,
  output logic            is_one,
  output logic            is_zero
);

  logic [CNTW-1:0] cnt_reg;

  // Load has priority; decrement is held off at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - CNTW'(1);
    end
  end

  assign cnt     = cnt_reg;
  assign is_one  = (cnt_reg == CNTW'(1));
  assign is_zero = (cnt_reg == '0);

endmodule

// File: rtl/m_qseq.sv
// Q-register sequencer: immediate expansion, Q clear and counted
// single-bit shift loop for the immediate-expander / zero-finder / Q datapath.
// Optional feature macro: M_QSEQ_ZSKIP_EN -- end the shift loop early once
// the zero-finder reports Q==0 (shifting zero yields zero).
module m_qseq
  import m_qseq_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            RST_I,
  input  logic            req,
  input  logic            clrq,
  input  logic            is_shift,
  input  logic            is_immop,
  input  logic [CNTW-1:0] shamt_imm,
  input  logic [CNTW-1:0] shamt_reg,
  input  logic            rzcy32,
  output logic            sa11,
  output logic            sa14,
  output logic            enaQ,
  output logic            shstep,
  output logic            busy,
  output logic            ack
);

  state_t          state_reg, state_next;
  logic [CNTW-1:0] shamt_sel;
  logic [CNTW-1:0] cnt_val;
  logic            cnt_is_one;
  logic            cnt_is_zero;
  logic            zskip_stop;
  logic            sa11_reg, sa14_reg, enaq_reg, shstep_reg, busy_reg, ack_reg;

  assign shamt_sel = is_immop ? shamt_imm : shamt_reg;

`ifdef M_QSEQ_ZSKIP_EN
  // Q already zero: further shifting cannot change it, so stop now.
  assign zskip_stop = ~rzcy32;
`else
  logic unused_cnt;
  assign zskip_stop = 1'b0;
  assign unused_cnt = rzcy32 ^ cnt_is_zero ^ (^cnt_val);
`endif

  m_qseq_cnt #(.CNTW(CNTW)) u_cnt (
    .clk      (clk),
    .srst     (RST_I),
    .load     (state_reg == SHLOAD),
    .dec      (state_reg == SHIFT),
    .load_val (shamt_sel),
    .cnt      (cnt_val),
    .is_one   (cnt_is_one),
    .is_zero  (cnt_is_zero)
  );

  // Next-state selection; mode inputs are looked at only in the state using them.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (req) state_next = clrq ? CLEAR : DECODE;
      CLEAR:   state_next = DECODE;
      DECODE:  state_next = is_shift ? SHLOAD : DONE;
      SHLOAD:  state_next = ((shamt_sel == '0) || zskip_stop) ? DONE : SHIFT;
      SHIFT:   state_next = (cnt_is_one || zskip_stop) ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register plus strobes decoded from the state being entered, so
  // every output is a flop and nothing depends combinationally on req.
  always_ff @(posedge clk) begin
    if (RST_I) begin
      state_reg  <= IDLE;
      sa11_reg   <= 1'b0;
      sa14_reg   <= 1'b0;
      enaq_reg   <= 1'b0;
      shstep_reg <= 1'b0;
      busy_reg   <= 1'b0;
      ack_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sa11_reg   <= (state_next == DECODE);
      sa14_reg   <= (state_next == CLEAR);
      enaq_reg   <= (state_next == CLEAR) || (state_next == DECODE) || (state_next == SHIFT);
      shstep_reg <= (state_next == SHIFT);
      busy_reg   <= (state_next != IDLE);
      ack_reg    <= (state_next == DONE);
    end
  end

  assign sa11 = sa11_reg;
  assign sa14 = sa14_reg;
  assign busy = busy_reg;
  assign ack  = ack_reg;

`ifdef M_QSEQ_ZSKIP_EN
  // The step that discovers Q==0 is suppressed: no shift, no Q write.
  assign shstep = shstep_reg & ~zskip_stop;
  assign enaQ   = enaq_reg & ~((state_reg == SHIFT) & zskip_stop);
`else
  assign shstep = shstep_reg;
  assign enaQ   = enaq_reg;
`endif

endmodule

// File: tb/tb_m_qseq.sv
// Self-checking bench for m_qseq: expected per-cycle output vectors are
// built from the operation's rules (clear, decode, load, n steps, done).
module tb_m_qseq;

  localparam int W = 5;

  // Output vector order: {sa11, sa14, enaQ, shstep, busy, ack}
  localparam logic [5:0] V_IDLE  = 6'b000000;
  localparam logic [5:0] V_CLR   = 6'b011010;
  localparam logic [5:0] V_DEC   = 6'b101010;
  localparam logic [5:0] V_SHL   = 6'b000010;
  localparam logic [5:0] V_SHIFT = 6'b001110;
  localparam logic [5:0] V_DONE  = 6'b000011;

  logic         clk = 1'b0;
  logic         RST_I, req, clrq, is_shift, is_immop, rzcy32;
  logic [W-1:0] shamt_imm, shamt_reg;
  logic         sa11, sa14, enaQ, shstep, busy, ack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  m_qseq #(.CNTW(W)) dut (
    .clk       (clk),
    .RST_I     (RST_I),
    .req       (req),
    .clrq      (clrq),
    .is_shift  (is_shift),
    .is_immop  (is_immop),
    .shamt_imm (shamt_imm),
    .shamt_reg (shamt_reg),
    .rzcy32    (rzcy32),
    .sa11      (sa11),
    .sa14      (sa14),
    .enaQ      (enaQ),
    .shstep    (shstep),
    .busy      (busy),
    .ack       (ack)
  );

  function automatic logic [5:0] outs();
    return {sa11, sa14, enaQ, shstep, busy, ack};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation from IDLE and checks every cycle through the return
  // to IDLE. zdrop>0 pulls rzcy32 low once that many steps have been seen.
  task automatic run_op(input bit c, input bit sh, input bit imm,
                        input logic [W-1:0] si, input logic [W-1:0] sr,
                        input int zdrop, output int steps, output int ackc);
    logic [5:0] exp_q[$];
    int n;
    bit keep_req;
    n = imm ? int'(si) : int'(sr);
    if (c) exp_q.push_back(V_CLR);
    exp_q.push_back(V_DEC);
    if (sh) begin
      exp_q.push_back(V_SHL);
`ifdef M_QSEQ_ZSKIP_EN
      if (zdrop > 0 && zdrop < n) begin
        for (int k = 0; k < zdrop; k++) exp_q.push_back(V_SHIFT);
        exp_q.push_back(V_SHL);  // suppressed step: busy only
      end else begin
        for (int k = 0; k < n; k++) exp_q.push_back(V_SHIFT);
      end
`else
      for (int k = 0; k < n; k++) exp_q.push_back(V_SHIFT);
`endif
    end
    exp_q.push_back(V_DONE);

    @(negedge clk);
    req = 1'b1; clrq = c; is_shift = sh; is_immop = imm;
    shamt_imm = si; shamt_reg = sr;
    rzcy32 = 1'b1;
    keep_req = 1'($urandom_range(0, 1));
    @(posedge clk);   // sample edge
    #1;
    clrq = 1'($urandom_range(0, 1));
    if (!keep_req) req = 1'b0;
    steps = 0; ackc = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check($sformatf("cyc%0d", i + 1), int'(outs()), int'(exp_q[i]));
      if (shstep) steps++;
      if (ack) begin ackc = i + 1; req = 1'b0; end
`ifndef M_QSEQ_ZSKIP_EN
      rzcy32 = 1'($urandom_range(0, 1));
`endif
      if (sh && i > (c ? 2 : 1)) begin
        shamt_imm = W'($urandom); shamt_reg = W'($urandom);
        is_immop = 1'($urandom_range(0, 1)); is_shift = 1'($urandom_range(0, 1));
      end
      if (zdrop > 0 && shstep && steps == zdrop) begin
        @(posedge clk); #1 rzcy32 = 1'b0;
      end
    end
    @(negedge clk);
    check("idle_after", int'(outs()), int'(V_IDLE));
    rzcy32 = 1'b1;
    $display("op clr=%0d sh=%0d imm=%0d n=%0d steps=%0d ack_cycle=%0d", c, sh, imm, n, steps, ackc);
  endtask

  initial begin
    int st, ac;
    RST_I = 1'b1; req = 1'b0; clrq = 1'b0; is_shift = 1'b0; is_immop = 1'b0;
    shamt_imm = '0; shamt_reg = '0; rzcy32 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", int'(outs()), int'(V_IDLE));
    RST_I = 1'b0;
    @(negedge clk);
    check("idle_outs", int'(outs()), int'(V_IDLE));

    // Directed cases with hand-computed step counts and ack latency.
    run_op(0, 0, 0, 5'd0, 5'd0, 0, st, ac);
    check("nonshift_steps", st, 0); check("nonshift_ack", ac, 2);
    run_op(1, 0, 0, 5'd0, 5'd0, 0, st, ac);
    check("clrq_ack", ac, 3);
    run_op(0, 1, 1, 5'd5, 5'd9, 0, st, ac);
    check("imm5_steps", st, 5); check("imm5_ack", ac, 8);
    run_op(0, 1, 0, 5'd7, 5'd0, 0, st, ac);
    check("reg0_steps", st, 0); check("reg0_ack", ac, 3);
    run_op(0, 1, 0, 5'd0, 5'd31, 0, st, ac);
    check("reg31_steps", st, 31); check("reg31_ack", ac, 34);
    run_op(1, 1, 1, 5'd2, 5'd0, 0, st, ac);
    check("clr_imm2_ack", ac, 6);

    // Zero-skip: rzcy32 falls after the 3rd step of a 10-step shift.
    run_op(0, 1, 0, 5'd0, 5'd10, 3, st, ac);
`ifdef M_QSEQ_ZSKIP_EN
    check("zskip_steps", st, 3); check("zskip_ack", ac, 7);
`else
    check("zskip_steps", st, 10); check("zskip_ack", ac, 13);
`endif

    // Reset in the middle of a 20-step shift, after 4 steps.
    @(negedge clk);
    req = 1'b1; clrq = 1'b0; is_shift = 1'b1; is_immop = 1'b0; shamt_reg = 5'd20;
    @(posedge clk);
    st = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (shstep) st++;
    end
    check("rst_pre_steps", st, 4);
    RST_I = 1'b1; req = 1'b0;
    @(negedge clk);
    check("rst_abort_outs", int'(outs()), int'(V_IDLE));
    RST_I = 1'b0;
    @(negedge clk);
    check("rst_idle_outs", int'(outs()), int'(V_IDLE));
    $display("reset during shift: steps_before=%0d", st);
    run_op(0, 1, 1, 5'd4, 5'd1, 0, st, ac);
    check("post_rst_steps", st, 4); check("post_rst_ack", ac, 7);

    // Randomized operations.
    for (int t = 0; t < 40; t++) begin
      bit rc, rs, ri;
      logic [W-1:0] a, b;
      int n;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      ri = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom);
      run_op(rc, rs, ri, a, b, 0, st, ac);
      n = rs ? (ri ? int'(a) : int'(b)) : 0;
      check("rnd_steps", st, n);
      check("rnd_ack", ac, (rc ? 1 : 0) + (rs ? n + 3 : 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
